// File: rtl/bcd_time_pkg.sv
// Shared constants and the load-validity rule for the BCD time-of-day counter.
package bcd_time_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    localparam int unsigned BASE_TW = 20;
    localparam int unsigned FRAC_TW = 8;
    localparam int unsigned MAX_TW  = BASE_TW + FRAC_TW;

    localparam int unsigned FRAC_W = 4;
    localparam int unsigned S_W    = 4;
    localparam int unsigned S10_W  = 3;
    localparam int unsigned M_W    = 4;
    localparam int unsigned M10_W  = 3;
    localparam int unsigned H_W    = 4;
    localparam int unsigned H10_W  = 2;

    // Offsets of the hh:mm:ss fields, relative to the LSB of the seconds digit.
    localparam int unsigned S_OFF   = 0;
    localparam int unsigned S10_OFF = 4;
    localparam int unsigned M_OFF   = 7;
    localparam int unsigned M10_OFF = 11;
    localparam int unsigned H_OFF   = 14;
    localparam int unsigned H10_OFF = 18;

    localparam int unsigned FRAC_OFF   = 0;
    localparam int unsigned FRAC10_OFF = 4;

    localparam int unsigned DIGIT_MAX_9 = 9;
    localparam int unsigned DIGIT_MAX_5 = 5;

    function automatic logic load_valid(input logic [MAX_TW-1:0] tv,
                                        input int unsigned       wrap_hours,
                                        input logic              frac_en);
        logic [BASE_TW-1:0] t;
        logic               ok;
        t  = frac_en ? tv[MAX_TW-1:FRAC_TW] : tv[BASE_TW-1:0];
        ok = (t[S_OFF   +: S_W]   <= 4'(DIGIT_MAX_9)) &&
             (t[S10_OFF +: S10_W] <= 3'(DIGIT_MAX_5)) &&
             (t[M_OFF   +: M_W]   <= 4'(DIGIT_MAX_9)) &&
             (t[M10_OFF +: M10_W] <= 3'(DIGIT_MAX_5)) &&
             (t[H_OFF   +: H_W]   <= 4'(DIGIT_MAX_9)) &&
             ((32'(t[H10_OFF +: H10_W]) * 32'd10 + 32'(t[H_OFF +: H_W])) < wrap_hours);
        if (frac_en) begin
            ok = ok && (tv[FRAC10_OFF +: FRAC_W] <= 4'(DIGIT_MAX_9)) &&
                       (tv[FRAC_OFF   +: FRAC_W] <= 4'(DIGIT_MAX_9));
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_counter_digit.sv
// Single BCD digit 0..MAX with wrap, load and combinational carry/borrow out.
module bcd_digit #(
    parameter int unsigned MAX = 9,
    parameter int unsigned W   = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_ld_val,
    output logic [W-1:0] o_q,
    output logic         o_carry_c
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] r_q;

    assign o_carry_c = (i_inc && (r_q == MAX_V)) || (i_dec && (r_q == '0));
    assign o_q       = r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_ld_val;
        end else if (i_inc) begin
            r_q <= (r_q == MAX_V) ? '0 : r_q + W'(1);
        end else if (i_dec) begin
            r_q <= (r_q == '0) ? MAX_V : r_q - W'(1);
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD hh:mm:ss(.cc) counter: up/down counting, validated load, rollover and expiry flags.
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int unsigned WRAP_HOURS = 12,
    parameter int unsigned FRAC_EN    = 0,
    parameter int unsigned TW         = BASE_TW + FRAC_TW * FRAC_EN
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [1:0]    mode,
    input  logic [TW-1:0] load_value,
    output logic [TW-1:0] present_time,
    output logic          rollover,
    output logic          expired,
    output logic          load_err
);

    localparam int unsigned        FB      = FRAC_TW * FRAC_EN;
    localparam logic [H10_W-1:0]   H10_TOP = H10_W'((WRAP_HOURS - 1) / 10);
    localparam logic [H_W-1:0]     H_TOP   = H_W'((WRAP_HOURS - 1) % 10);

    logic              w_up_tick;
    logic              w_down_en;
    logic              w_valid;
    logic              w_load_ok;
    logic              w_all_zero;
    logic              w_is_one;
    logic              w_hr_max;
    logic              w_sec_en;
    logic [S_W-1:0]    w_s_q;
    logic [S10_W-1:0]  w_s10_q;
    logic [M_W-1:0]    w_m_q;
    logic [M10_W-1:0]  w_m10_q;
    logic              w_s_co;
    logic              w_s10_co;
    logic              w_m_co;
    logic              w_m10_co;

    logic [H10_W-1:0]  r_h10;
    logic [H_W-1:0]    r_h;
    logic              r_rollover;
    logic              r_expired;
    logic              r_load_err;

    assign w_valid    = load_valid(MAX_TW'(load_value), WRAP_HOURS, FRAC_EN != 0);
    assign w_load_ok  = (mode == MODE_LOAD) && w_valid;
    assign w_all_zero = (present_time == '0);
    assign w_is_one   = (present_time == TW'(1));
    assign w_hr_max   = (r_h10 == H10_TOP) && (r_h == H_TOP);
    assign w_up_tick  = tick && (mode == MODE_UP);
    // Counting down stops at zero; it never wraps below.
    assign w_down_en  = tick && (mode == MODE_DOWN) && !w_all_zero;

    generate
        if (FRAC_EN != 0) begin : g_frac
            logic [FRAC_W-1:0] w_f0_q;
            logic [FRAC_W-1:0] w_f1_q;
            logic              w_f0_co;
            logic              w_f1_co;

            bcd_digit #(.MAX(DIGIT_MAX_9), .W(FRAC_W)) u_f0 (
                .i_clk(clk), .i_rst(rst),
                .i_inc(w_up_tick), .i_dec(w_down_en), .i_clr(1'b0), .i_load(w_load_ok),
                .i_ld_val(load_value[FRAC_OFF +: FRAC_W]),
                .o_q(w_f0_q), .o_carry_c(w_f0_co)
            );
            bcd_digit #(.MAX(DIGIT_MAX_9), .W(FRAC_W)) u_f1 (
                .i_clk(clk), .i_rst(rst),
                .i_inc(w_up_tick && w_f0_co), .i_dec(w_down_en && w_f0_co), .i_clr(1'b0),
                .i_load(w_load_ok), .i_ld_val(load_value[FRAC10_OFF +: FRAC_W]),
                .o_q(w_f1_q), .o_carry_c(w_f1_co)
            );

            assign w_sec_en     = w_f1_co;
            assign present_time = TW'({r_h10, r_h, w_m10_q, w_m_q, w_s10_q, w_s_q, w_f1_q, w_f0_q});
        end else begin : g_nofrac
            assign w_sec_en     = 1'b1;
            assign present_time = TW'({r_h10, r_h, w_m10_q, w_m_q, w_s10_q, w_s_q});
        end
    endgenerate

    bcd_digit #(.MAX(DIGIT_MAX_9), .W(S_W)) u_s (
        .i_clk(clk), .i_rst(rst),
        .i_inc(w_up_tick && w_sec_en), .i_dec(w_down_en && w_sec_en), .i_clr(1'b0),
        .i_load(w_load_ok), .i_ld_val(load_value[FB + S_OFF +: S_W]),
        .o_q(w_s_q), .o_carry_c(w_s_co)
    );
    bcd_digit #(.MAX(DIGIT_MAX_5), .W(S10_W)) u_s10 (
        .i_clk(clk), .i_rst(rst),
        .i_inc(w_up_tick && w_s_co), .i_dec(w_down_en && w_s_co), .i_clr(1'b0),
        .i_load(w_load_ok), .i_ld_val(load_value[FB + S10_OFF +: S10_W]),
        .o_q(w_s10_q), .o_carry_c(w_s10_co)
    );
    bcd_digit #(.MAX(DIGIT_MAX_9), .W(M_W)) u_m (
        .i_clk(clk), .i_rst(rst),
        .i_inc(w_up_tick && w_s10_co), .i_dec(w_down_en && w_s10_co), .i_clr(1'b0),
        .i_load(w_load_ok), .i_ld_val(load_value[FB + M_OFF +: M_W]),
        .o_q(w_m_q), .o_carry_c(w_m_co)
    );
    bcd_digit #(.MAX(DIGIT_MAX_5), .W(M10_W)) u_m10 (
        .i_clk(clk), .i_rst(rst),
        .i_inc(w_up_tick && w_m_co), .i_dec(w_down_en && w_m_co), .i_clr(1'b0),
        .i_load(w_load_ok), .i_ld_val(load_value[FB + M10_OFF +: M10_W]),
        .o_q(w_m10_q), .o_carry_c(w_m10_co)
    );

    // Hour pair wraps at WRAP_HOURS-1, so it is kept here rather than as two digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h10 <= '0;
            r_h   <= '0;
        end else if (w_load_ok) begin
            r_h10 <= load_value[FB + H10_OFF +: H10_W];
            r_h   <= load_value[FB + H_OFF +: H_W];
        end else if (w_up_tick && w_m10_co) begin
            if (w_hr_max) begin
                r_h10 <= '0;
                r_h   <= '0;
            end else if (r_h == 4'd9) begin
                r_h10 <= r_h10 + 2'd1;
                r_h   <= '0;
            end else begin
                r_h   <= r_h + 4'd1;
            end
        end else if (w_down_en && w_m10_co) begin
            if (r_h == '0) begin
                r_h10 <= r_h10 - 2'd1;
                r_h   <= 4'd9;
            end else begin
                r_h   <= r_h - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rollover <= 1'b0;
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_rollover <= w_up_tick && w_m10_co && w_hr_max;
            r_load_err <= (mode == MODE_LOAD) && !w_valid;
            case (mode)
                MODE_LOAD: if (w_valid) r_expired <= 1'b0;
                MODE_UP:   r_expired <= 1'b0;
                MODE_DOWN: if (tick && (w_all_zero || w_is_one)) r_expired <= 1'b1;
                MODE_HOLD: r_expired <= r_expired;
            endcase
        end
    end

    assign rollover = r_rollover;
    assign expired  = r_expired;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: three configurations (12h, 24h, 24h+hundredths) against a units-count model.
module tb_bcd_time_counter;

    localparam logic [1:0] M_UP   = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_HOLD = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        tk [3];
    logic [1:0]  md [3];
    logic [27:0] lv [3];
    logic [19:0] pt0;
    logic [19:0] pt1;
    logic [27:0] pt2;
    logic [2:0]  ro;
    logic [2:0]  ex;
    logic [2:0]  le;

    int units [3];
    bit mexp  [3];
    bit mroll [3];
    bit mlerr [3];
    int wrap  [3] = '{12, 24, 24};
    bit frac  [3] = '{1'b0, 1'b0, 1'b1};
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_time_counter #(.WRAP_HOURS(12), .FRAC_EN(0)) dut12 (
        .clk(clk), .rst(rst), .tick(tk[0]), .mode(md[0]), .load_value(lv[0][19:0]),
        .present_time(pt0), .rollover(ro[0]), .expired(ex[0]), .load_err(le[0])
    );
    bcd_time_counter #(.WRAP_HOURS(24), .FRAC_EN(0)) dut24 (
        .clk(clk), .rst(rst), .tick(tk[1]), .mode(md[1]), .load_value(lv[1][19:0]),
        .present_time(pt1), .rollover(ro[1]), .expired(ex[1]), .load_err(le[1])
    );
    bcd_time_counter #(.WRAP_HOURS(24), .FRAC_EN(1)) dutf (
        .clk(clk), .rst(rst), .tick(tk[2]), .mode(md[2]), .load_value(lv[2]),
        .present_time(pt2), .rollover(ro[2]), .expired(ex[2]), .load_err(le[2])
    );

    function automatic int scale(int k);
        return frac[k] ? 100 : 1;
    endfunction

    function automatic int umax(int k);
        return wrap[k] * 3600 * scale(k);
    endfunction

    function automatic logic [27:0] raw(int k, int h10, int h, int m10, int m,
                                        int s10, int s, int f10, int f);
        logic [27:0] v;
        v = {8'd0, 2'(h10), 4'(h), 3'(m10), 4'(m), 3'(s10), 4'(s)};
        if (frac[k]) v = (v << 8) | {20'd0, 4'(f10), 4'(f)};
        return v;
    endfunction

    function automatic int tod(int k, int h, int m, int s, int f);
        return ((h * 60 + m) * 60 + s) * scale(k) + f;
    endfunction

    function automatic logic [27:0] enc(int k, int u);
        int f, sec, h, m, s;
        f   = frac[k] ? u % 100 : 0;
        sec = u / scale(k);
        h   = sec / 3600;
        m   = (sec / 60) % 60;
        s   = sec % 60;
        return raw(k, h / 10, h % 10, m / 10, m % 10, s / 10, s % 10, f / 10, f % 10);
    endfunction

    function automatic bit dec_valid(int k, logic [27:0] v, output int u);
        logic [27:0] t;
        int h10, h, m10, m, s10, s, f10, f;
        t   = frac[k] ? (v >> 8) : v;
        s   = int'(t[3:0]);   s10 = int'(t[6:4]);
        m   = int'(t[10:7]);  m10 = int'(t[13:11]);
        h   = int'(t[17:14]); h10 = int'(t[19:18]);
        f   = frac[k] ? int'(v[3:0]) : 0;
        f10 = frac[k] ? int'(v[7:4]) : 0;
        u   = (((h10 * 10 + h) * 60 + m10 * 10 + m) * 60 + s10 * 10 + s) * scale(k) + f10 * 10 + f;
        return s <= 9 && s10 <= 5 && m <= 9 && m10 <= 5 && h <= 9 &&
               (h10 * 10 + h) < wrap[k] && f <= 9 && f10 <= 9;
    endfunction

    function automatic logic [27:0] pt_of(int k);
        case (k)
            0:       return {8'd0, pt0};
            1:       return {8'd0, pt1};
            default: return pt2;
        endcase
    endfunction

    function automatic logic [30:0] obs(int k);
        return {pt_of(k), ro[k], ex[k], le[k]};
    endfunction

    function automatic logic [30:0] expv(int k);
        return {enc(k, units[k]), 1'(mroll[k]), 1'(mexp[k]), 1'(mlerr[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            units[k] = 0; mexp[k] = 1'b0; mroll[k] = 1'b0; mlerr[k] = 1'b0;
        end
    endtask

    // One clock of stimulus for configuration k, with the model stepped on the same edge.
    task automatic drive(int k, bit t, logic [1:0] m, logic [27:0] v);
        int u;
        tk[k] = t; md[k] = m; lv[k] = v;
        @(posedge clk);
        mroll[k] = 1'b0;
        mlerr[k] = 1'b0;
        case (m)
            M_LOAD: if (dec_valid(k, v, u)) begin units[k] = u; mexp[k] = 1'b0; end
                    else mlerr[k] = 1'b1;
            M_UP: begin
                mexp[k] = 1'b0;
                if (t) begin
                    units[k]++;
                    if (units[k] == umax(k)) begin units[k] = 0; mroll[k] = 1'b1; end
                end
            end
            M_DOWN: if (t) begin
                if (units[k] > 0) units[k]--;
                if (units[k] == 0) mexp[k] = 1'b1;
            end
            default: ;
        endcase
        #1;
        tk[k] = 1'b0; md[k] = M_HOLD;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL reset_state[%0d]: got %h want %h", k, obs(k), expv(k));
            end
        end
        rst = 1'b0;
        drive(0, 1'b0, M_LOAD, enc(0, tod(0, 5, 32, 16, 0)));
        drive(0, 1'b1, M_UP, 28'd0);
        checks++;
        if (obs(0) !== expv(0)) begin
            errors++; $display("FAIL pre_reset_count: got %h want %h", obs(0), expv(0));
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
                errors++; $display("FAIL async_reset[%0d]: got %h want %h", k, obs(k), expv(k));
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1'b1, M_UP, 28'd0);
        checks++;
        if (pt0 !== 20'h00001 || ro[0] !== 1'b0) begin
            errors++; $display("FAIL first_tick_after_reset: got %h want %h", pt0, 20'h00001);
        end
    endtask

    task automatic test_wrap12();
        logic [1:0]  ms [6];
        bit          ts [6];
        logic [27:0] vs [6];
        ms = '{M_LOAD, M_UP, M_UP, M_UP, M_LOAD, M_UP};
        ts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vs = '{enc(0, tod(0, 11, 59, 58, 0)), 28'd0, 28'd0, 28'd0, enc(0, tod(0, 9, 59, 59, 0)), 28'd0};
        for (int i = 0; i < 6; i++) begin
            drive(0, ts[i], ms[i], vs[i]);
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++; $display("FAIL wrap12 step %0d: got %h want %h", i, obs(0), expv(0));
            end
            if (i == 2) begin
                checks++;
                if (pt0 !== 20'h0 || ro[0] !== 1'b1) begin
                    errors++; $display("FAIL wrap12_rollover: got %h/%b want 00000/1", pt0, ro[0]);
                end
            end
        end
        checks++;
        if (pt0 !== 20'h40000) begin
            errors++; $display("FAIL hour_09_to_10: got %h want %h", pt0, 20'h40000);
        end
    endtask

    task automatic test_wrap24();
        logic [1:0]  ms [6];
        bit          ts [6];
        logic [27:0] vs [6];
        ms = '{M_LOAD, M_UP, M_LOAD, M_UP, M_LOAD, M_UP};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vs = '{enc(1, tod(1, 12, 59, 59, 0)), 28'd0, enc(1, tod(1, 23, 59, 59, 0)), 28'd0,
               enc(1, tod(1, 19, 59, 59, 0)), 28'd0};
        for (int i = 0; i < 6; i++) begin
            drive(1, ts[i], ms[i], vs[i]);
            checks++;
            if (obs(1) !== expv(1)) begin
                errors++; $display("FAIL wrap24 step %0d: got %h want %h", i, obs(1), expv(1));
            end
            if (i == 1) begin
                checks++;
                if (pt1 !== 20'h4C000) begin
                    errors++; $display("FAIL hour_12_to_13: got %h want %h", pt1, 20'h4C000);
                end
            end
        end
        checks++;
        if (pt1 !== 20'h80000) begin
            errors++; $display("FAIL hour_19_to_20: got %h want %h", pt1, 20'h80000);
        end
    endtask

    task automatic test_down();
        logic [1:0]  ms [9];
        bit          ts [9];
        logic [27:0] vs [9];
        ms = '{M_LOAD, M_DOWN, M_LOAD, M_DOWN, M_DOWN, M_DOWN, M_DOWN, M_UP, M_UP};
        ts = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vs = '{enc(0, tod(0, 1, 0, 0, 0)), 28'd0, enc(0, tod(0, 0, 0, 1, 0)),
               28'd0, 28'd0, 28'd0, 28'd0, 28'd0, 28'd0};
        for (int i = 0; i < 9; i++) begin
            drive(0, ts[i], ms[i], vs[i]);
            checks++;
            if (obs(0) !== expv(0)) begin
                errors++; $display("FAIL countdown step %0d: got %h want %h", i, obs(0), expv(0));
            end
            if (i == 3) begin
                checks++;
                if (pt0 !== 20'h0 || ex[0] !== 1'b1) begin
                    errors++; $display("FAIL expire_at_zero: got %h/%b want 00000/1", pt0, ex[0]);
                end
            end
        end
    endtask

    task automatic test_load_err();
        int          ks [7];
        logic [27:0] vs [7];
        ks = '{0, 0, 0, 0, 0, 1, 2};
        vs = '{enc(0, tod(0, 7, 8, 9, 0)), raw(0, 0, 0, 6, 0, 0, 0, 0, 0),
               raw(0, 0, 0, 0, 0, 0, 10, 0, 0), raw(0, 1, 2, 0, 0, 0, 0, 0, 0),
               enc(0, tod(0, 3, 4, 5, 0)), raw(1, 2, 4, 0, 0, 0, 0, 0, 0),
               raw(2, 0, 0, 0, 0, 0, 0, 10, 0)};
        for (int i = 0; i < 7; i++) begin
            drive(ks[i], 1'b0, M_LOAD, vs[i]);
            checks++;
            if (obs(ks[i]) !== expv(ks[i])) begin
                errors++; $display("FAIL load_check %0d: got %h want %h", i, obs(ks[i]), expv(ks[i]));
            end
        end
    endtask

    task automatic test_hold_frac();
        drive(0, 1'b0, M_LOAD, enc(0, tod(0, 4, 5, 6, 0)));
        for (int i = 0; i < 13; i++) begin
            drive(0, i >= 10, (i >= 10) ? M_HOLD : M_UP, 28'd0);
            checks++;
            if (pt0 !== enc(0, tod(0, 4, 5, 6, 0))) begin
                errors++; $display("FAIL hold cycle %0d: got %h want %h", i, pt0, enc(0, tod(0, 4, 5, 6, 0)));
            end
        end
        drive(2, 1'b0, M_LOAD, enc(2, tod(2, 0, 0, 0, 99)));
        drive(2, 1'b1, M_UP, 28'd0);
        checks++;
        if (pt2 !== 28'h0000100) begin
            errors++; $display("FAIL frac_carry: got %h want %h", pt2, 28'h0000100);
        end
        drive(2, 1'b0, M_LOAD, 28'd0);
        drive(2, 1'b1, M_DOWN, 28'd0);
        checks++;
        if (obs(2) !== expv(2) || ex[2] !== 1'b1) begin
            errors++; $display("FAIL frac_down_at_zero: got %h want %h", obs(2), expv(2));
        end
    endtask

    task automatic test_random();
        int          sel;
        bit          t;
        logic [1:0]  m;
        logic [27:0] v;
        logic [27:0] mask;
        for (int k = 0; k < 3; k++) begin
            mask = frac[k] ? 28'hFFFFFFF : 28'h00FFFFF;
            for (int n = 0; n < 400; n++) begin
                sel = int'($urandom_range(0, 9));
                t   = ($urandom_range(0, 9) < 7);
                v   = 28'd0;
                if (sel <= 1) begin
                    m = M_LOAD;
                    case ($urandom_range(0, 3))
                        0:       v = 28'($urandom) & mask;
                        1:       v = enc(k, umax(k) - 1 - int'($urandom_range(0, 2)));
                        2:       v = enc(k, int'($urandom_range(0, 3)));
                        default: v = enc(k, int'($urandom % 32'(umax(k))));
                    endcase
                end else if (sel <= 5) m = M_UP;
                else if (sel <= 8)     m = M_DOWN;
                else                   m = M_HOLD;
                drive(k, t, m, v);
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++; $display("FAIL random[%0d] cycle %0d: got %h want %h", k, n, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tk[k] = 1'b0; md[k] = M_HOLD; lv[k] = 28'd0;
        end
        model_reset();
        test_reset();
        test_wrap12();
        test_wrap24();
        test_down();
        test_load_err();
        test_hold_frac();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
